// File: rtl/ripple_add_sequencer.sv
// Sequential WIDTH-bit adder built from one shared 4-bit ripple slice.
// Feeds the slice a nibble per clock, LSB first, carrying between cycles.
module ripple_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (idx == LAST) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Slice results are only captured in RUN, so X outside RUN never lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    carry <= add_cout;
                    for (int i = 0; i < NSLICE; i++) begin
                        if (idx == IW'(i)) begin
                            sum[4*i +: 4] <= add_s;
                        end
                    end
                    if (idx == LAST) begin
                        cout <= add_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_cin = carry;
            for (int i = 0; i < NSLICE; i++) begin
                if (idx == IW'(i)) begin
                    add_a = a_q[4*i +: 4];
                    add_b = b_q[4*i +: 4];
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Randomized bench for ripple_add_sequencer against an arithmetic model.
// Covers WIDTH=16 and WIDTH=4 instances with a behavioural slice.
module tb_ripple_add_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_s;
    logic        add_cout;

    logic        start4;
    logic [3:0]  op_a4;
    logic [3:0]  op_b4;
    logic        cin4;
    logic        busy4;
    logic        done4;
    logic [3:0]  sum4;
    logic        cout4;
    logic [3:0]  add_a4;
    logic [3:0]  add_b4;
    logic        add_cin4;
    logic [3:0]  add_s4;
    logic        add_cout4;

    assign {add_cout, add_s} =
        5'(add_a) + 5'(add_b) + 5'(add_cin);
    assign {add_cout4, add_s4} =
        5'(add_a4) + 5'(add_b4) + 5'(add_cin4);

    ripple_add_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op_a(op_a), .op_b(op_b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
    );

    ripple_add_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .op_a(op_a4), .op_b(op_b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_s(add_s4), .add_cout(add_cout4)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle16(input string tag,
                          input logic [16:0] exp);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_add_a"}, 32'(add_a), 32'd0);
        check({tag, "_add_b"}, 32'(add_b), 32'd0);
        check({tag, "_add_cin"}, 32'(add_cin), 32'd0);
        check({tag, "_hold"}, 32'({cout, sum}), 32'(exp));
    endtask

    // One transaction: latency, result, per-slice carry-in and A nibbles
    task automatic run16(input logic [15:0] a,
                         input logic [15:0] b,
                         input logic c,
                         input string tag);
        logic [16:0] exp;
        logic [3:0]  seen_cin;
        logic [3:0]  exp_cin;
        logic [15:0] seen_a;
        logic [31:0] m;
        logic [31:0] part;
        int n;
        exp = 17'(a) + 17'(b) + 17'(c);
        for (int i = 0; i < 4; i++) begin
            m = (32'd1 << (4 * i)) - 32'd1;
            part = (32'(a) & m) + (32'(b) & m) + 32'(c);
            exp_cin[i] = part[4*i];
        end
        seen_cin = '0;
        seen_a = '0;
        op_a = a;
        op_b = b;
        cin = c;
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            if (busy && n <= 4) begin
                seen_cin[n-1] = add_cin;
                seen_a[4*(n-1) +: 4] = add_a;
            end
            op_a = 16'($urandom);
            op_b = 16'($urandom);
            cin = 1'($urandom);
            tick;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd5);
        check({tag, "_sum"}, 32'(sum), 32'(exp[15:0]));
        check({tag, "_cout"}, 32'(cout), 32'(exp[16]));
        check({tag, "_cin_seq"}, 32'(seen_cin), 32'(exp_cin));
        check({tag, "_a_seq"}, 32'(seen_a), 32'(a));
        tick;
        idle16(tag, exp);
    endtask

    task automatic run4(input logic [3:0] a,
                        input logic [3:0] b,
                        input logic c,
                        input string tag);
        logic [4:0] exp;
        int n;
        exp = 5'(a) + 5'(b) + 5'(c);
        op_a4 = a;
        op_b4 = b;
        cin4 = c;
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        op_a4 = 4'($urandom);
        n = 1;
        while (!done4 && n < 10) begin
            tick;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd2);
        check({tag, "_sum"}, 32'(sum4), 32'(exp[3:0]));
        check({tag, "_cout"}, 32'(cout4), 32'(exp[4]));
        tick;
        check({tag, "_busy"}, 32'(busy4), 32'd0);
        check({tag, "_hold"}, 32'({cout4, sum4}), 32'(exp));
    endtask

    logic [15:0] pa [0:18];
    logic [15:0] pb [0:18];
    logic        pc [0:18];
    logic [16:0] e;
    bit          want;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op_a = '0;
        op_b = '0;
        cin = 1'b0;
        start4 = 1'b0;
        op_a4 = '0;
        op_b4 = '0;
        cin4 = 1'b0;
        #1;
        idle16("reset", 17'd0);
        check("reset_w4", 32'({busy4, done4, cout4, sum4}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        idle16("post_reset", 17'd0);

        run16(16'h0000, 16'h0000, 1'b0, "zero");
        run16(16'hFFFF, 16'h0001, 1'b0, "ripple");
        run16(16'h1234, 16'h4321, 1'b1, "mixed");
        op_a = 16'hDEAD;
        repeat (3) tick;
        check("mixed_hold_late", 32'({cout, sum}), 32'h05556);

        // start held high while operands change every cycle
        for (int k = 0; k <= 18; k++) begin
            pa[k] = 16'($urandom);
            pb[k] = 16'($urandom);
            pc[k] = 1'($urandom);
        end
        op_a = pa[0];
        op_b = pb[0];
        cin = pc[0];
        start = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick;
            want = (k == 5 || k == 11 || k == 17);
            check("stream_done", 32'(done), 32'(want));
            if (want) begin
                e = 17'(pa[k-5]) + 17'(pb[k-5]) + 17'(pc[k-5]);
                check("stream_res", 32'({cout, sum}), 32'(e));
            end
            op_a = pa[k];
            op_b = pb[k];
            cin = pc[k];
        end
        start = 1'b0;
        check("stream_idle", 32'(busy), 32'd0);
        tick;

        // reset asserted in RUN at idx=2
        op_a = 16'h1111;
        op_b = 16'h2222;
        cin = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        check("mid_idx2_a", 32'(add_a), 32'h1);
        check("mid_idx2_b", 32'(add_b), 32'h2);
        rst_n = 1'b0;
        #1;
        idle16("mid_reset", 17'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        run16(16'h00FF, 16'h0F01, 1'b0, "after_reset");
        check("after_reset_val", 32'({cout, sum}), 32'h01000);

        for (int r = 0; r < 12; r++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), "rand16");
        end

        run4(4'hF, 4'hF, 1'b1, "w4_max");
        for (int r = 0; r < 6; r++) begin
            run4(4'($urandom), 4'($urandom), 1'($urandom), "rand4");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
